// File: rtl/keypad_pkg.sv
// Shared key codes, entry states and key classification helpers for the keypad entry FSM.
// Optional feature macro used by the top: KEY_ERR_EN.
package keypad_pkg;

   localparam logic [3:0] KEY_ADD   = 4'd10;
   localparam logic [3:0] KEY_SUB   = 4'd11;
   localparam logic [3:0] KEY_ENTER = 4'd12;
   localparam logic [3:0] KEY_RES13 = 4'd13;
   localparam logic [3:0] KEY_RES14 = 4'd14;
   localparam logic [3:0] KEY_MULTI = 4'd15;

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_B   = 2'd1,
      S_CMD = 2'd2
   } entry_state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

   function automatic logic is_op(input logic [3:0] k);
      return (k == KEY_ADD) || (k == KEY_SUB);
   endfunction

   function automatic logic is_bad(input logic [3:0] k);
      return (k == KEY_RES13) || (k == KEY_RES14) || (k == KEY_MULTI);
   endfunction

endpackage

// File: rtl/strobe_edge_det.sv
// Turns the level keystrobe from the encoder into a one-cycle press pulse.
// Part of keypad_entry_fsm (KEY_ERR_EN does not affect this block).
module strobe_edge_det (
   input  logic clk,
   input  logic nrst,
   input  logic keystrobe,
   output logic press
);

   logic strobe_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) strobe_q <= 1'b0;
      else       strobe_q <= keystrobe;
   end

   assign press = keystrobe & ~strobe_q;

endmodule

// File: rtl/keypad_entry_fsm.sv
// Assembles {A, op, B} calculator commands from keypad presses; valid/ready to the ALU.
// Define KEY_ERR_EN to flag codes 13/14/15 as a sticky entry error.
module keypad_entry_fsm
   import keypad_pkg::*;
#(
   parameter int MAX_DIGITS = 4,
   parameter int WIDTH      = 14
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [3:0]       keycode,
   input  logic             keystrobe,
   input  logic             cmd_ready,
   output logic             cmd_valid,
   output logic [WIDTH-1:0] operand_a,
   output logic [WIDTH-1:0] operand_b,
   output logic             op_sub,
   output logic [WIDTH-1:0] display_val,
   output logic             err
);

   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int XW = WIDTH + 4;

   entry_state_t     state;
   logic             press;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] cur;
   logic [XW-1:0]    acc_ext;
   logic [WIDTH-1:0] acc;
   logic             room;

   strobe_edge_det u_edge (
      .clk       (clk),
      .nrst      (nrst),
      .keystrobe (keystrobe),
      .press     (press)
   );

   // Shared decimal shift-in for whichever operand is being typed.
   assign cur     = (state == S_A) ? operand_a : operand_b;
   assign acc_ext = {4'b0, cur} * XW'(10) + XW'(keycode);
   assign acc     = acc_ext[WIDTH-1:0];
   assign room    = cnt < CW'(MAX_DIGITS);

   assign display_val = cur;

`ifdef KEY_ERR_EN
   logic err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_A;
         cnt       <= '0;
         operand_a <= '0;
         operand_b <= '0;
         op_sub    <= 1'b0;
         cmd_valid <= 1'b0;
`ifdef KEY_ERR_EN
         err_q     <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_A: begin
               if (press && is_digit(keycode)) begin
`ifdef KEY_ERR_EN
                  err_q <= 1'b0;
`endif
                  if (room) begin
                     operand_a <= acc;
                     cnt       <= cnt + CW'(1);
                  end
               end else if (press && is_op(keycode)) begin
                  op_sub    <= (keycode == KEY_SUB);
                  cnt       <= '0;
                  operand_b <= '0;
                  state     <= S_B;
`ifdef KEY_ERR_EN
               end else if (press && is_bad(keycode)) begin
                  err_q     <= 1'b1;
                  operand_a <= '0;
                  operand_b <= '0;
                  cnt       <= '0;
                  op_sub    <= 1'b0;
`endif
               end
            end
            S_B: begin
               if (press && is_digit(keycode)) begin
`ifdef KEY_ERR_EN
                  err_q <= 1'b0;
`endif
                  if (room) begin
                     operand_b <= acc;
                     cnt       <= cnt + CW'(1);
                  end
               end else if (press && is_op(keycode)) begin
                  if (cnt == '0) op_sub <= (keycode == KEY_SUB);
               end else if (press && keycode == KEY_ENTER) begin
                  state     <= S_CMD;
                  cmd_valid <= 1'b1;
`ifdef KEY_ERR_EN
               end else if (press && is_bad(keycode)) begin
                  err_q     <= 1'b1;
                  operand_a <= '0;
                  operand_b <= '0;
                  cnt       <= '0;
                  op_sub    <= 1'b0;
                  state     <= S_A;
`endif
               end
            end
            S_CMD: begin
               if (cmd_valid && cmd_ready) begin
                  operand_a <= '0;
                  operand_b <= '0;
                  cnt       <= '0;
                  cmd_valid <= 1'b0;
                  state     <= S_A;
               end
            end
            default: state <= S_A;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_entry_fsm.sv
// Directed bench for keypad_entry_fsm: vector table plus multi-cycle corner sequences.
// Honours KEY_ERR_EN the same way as the design.
module tb_keypad_entry_fsm;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [3:0]  keycode = 4'd0;
   logic        keystrobe = 1'b0;
   logic        cmd_ready = 1'b0;
   logic        cmd_valid;
   logic [13:0] operand_a;
   logic [13:0] operand_b;
   logic        op_sub;
   logic [13:0] display_val;
   logic        err;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   keypad_entry_fsm dut (
      .clk         (clk),
      .nrst        (nrst),
      .keycode     (keycode),
      .keystrobe   (keystrobe),
      .cmd_ready   (cmd_ready),
      .cmd_valid   (cmd_valid),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .op_sub      (op_sub),
      .display_val (display_val),
      .err         (err)
   );

   typedef struct {
      logic [3:0]  code;
      logic [13:0] disp;
      logic        valid;
      logic        op;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] k);
      @(negedge clk);
      keycode = k;
      keystrobe = 1'b1;
      @(negedge clk);
      keystrobe = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      nrst = 1'b0;
      keystrobe = 1'b0;
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      chk("rst_valid", int'(cmd_valid), 0);
      chk("rst_a", int'(operand_a), 0);
      chk("rst_b", int'(operand_b), 0);
      chk("rst_disp", int'(display_val), 0);
      chk("rst_err", int'(err), 0);
   endtask

   initial begin
      vecs[0] = '{4'd1,  14'd1,   1'b0, 1'b0};
      vecs[1] = '{4'd2,  14'd12,  1'b0, 1'b0};
      vecs[2] = '{4'd3,  14'd123, 1'b0, 1'b0};
      vecs[3] = '{4'd10, 14'd0,   1'b0, 1'b0};
      vecs[4] = '{4'd4,  14'd4,   1'b0, 1'b0};
      vecs[5] = '{4'd5,  14'd45,  1'b0, 1'b0};
      vecs[6] = '{4'd12, 14'd45,  1'b1, 1'b0};

      do_reset();

      // main entry, downstream stalled until the command is up
      foreach (vecs[i]) begin
         press(vecs[i].code);
         chk($sformatf("vec%0d_disp", i), int'(display_val), int'(vecs[i].disp));
         chk($sformatf("vec%0d_valid", i), int'(cmd_valid), int'(vecs[i].valid));
         chk($sformatf("vec%0d_op", i), int'(op_sub), int'(vecs[i].op));
      end
      chk("t2_a", int'(operand_a), 123);
      chk("t2_b", int'(operand_b), 45);
      press(4'd7);
      chk("t2_cmd_ignores_key", int'(operand_b), 45);
      cmd_ready = 1'b1;
      @(negedge clk);
      chk("t2_valid_drop", int'(cmd_valid), 0);
      chk("t2_clear_a", int'(operand_a), 0);
      cmd_ready = 1'b0;

      // held digit acts once
      @(negedge clk);
      keycode = 4'd7;
      keystrobe = 1'b1;
      repeat (5) @(negedge clk);
      keystrobe = 1'b0;
      chk("t3_hold", int'(operand_a), 7);
      do_reset();

      // digit limit, SUB, stalled handshake
      repeat (6) press(4'd9);
      chk("t4_limit", int'(display_val), 9999);
      press(4'd11);
      press(4'd12);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("t4_stall%0d_valid", c), int'(cmd_valid), 1);
         chk($sformatf("t4_stall%0d_a", c), int'(operand_a), 9999);
         chk($sformatf("t4_stall%0d_b", c), int'(operand_b), 0);
         chk($sformatf("t4_stall%0d_op", c), int'(op_sub), 1);
         if (c < 2) @(negedge clk);
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      chk("t4_drop", int'(cmd_valid), 0);

      // operator replacement, then operator after digit ignored
      press(4'd5); press(4'd10); press(4'd11); press(4'd2); press(4'd12);
      chk("t5a_valid", int'(cmd_valid), 1);
      chk("t5a_op", int'(op_sub), 1);
      chk("t5a_a", int'(operand_a), 5);
      chk("t5a_b", int'(operand_b), 2);
      press(4'd5); press(4'd10); press(4'd2); press(4'd11); press(4'd3);
      press(4'd12);
      chk("t5b_valid", int'(cmd_valid), 1);
      chk("t5b_op", int'(op_sub), 0);
      chk("t5b_a", int'(operand_a), 5);
      chk("t5b_b", int'(operand_b), 23);
      @(negedge clk);
      chk("t5b_drop", int'(cmd_valid), 0);
      cmd_ready = 1'b0;

      // ENTER in S_A does nothing
      press(4'd12);
      chk("enter_in_a", int'(cmd_valid), 0);

`ifdef KEY_ERR_EN
      press(4'd4);
      press(4'd15);
      chk("t6_err_set", int'(err), 1);
      chk("t6_err_disp", int'(display_val), 0);
      press(4'd6);
      chk("t6_err_clr", int'(err), 0);
      chk("t6_a", int'(operand_a), 6);
`else
      press(4'd4);
      press(4'd15);
      press(4'd6);
      chk("t6_err", int'(err), 0);
      chk("t6_a", int'(operand_a), 46);
`endif
      do_reset();

      // async reset while typing B
      press(4'd1); press(4'd10); press(4'd2);
      chk("t6_b_pre", int'(display_val), 2);
      #2 nrst = 1'b0;
      #1;
      chk("t6_async_a", int'(operand_a), 0);
      chk("t6_async_disp", int'(display_val), 0);
      @(negedge clk);
      nrst = 1'b1;
      press(4'd8);
      chk("t6_back_in_a", int'(operand_a), 8);
      chk("t6_b_zero", int'(operand_b), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
